// File: rtl/seq_chunk_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_chunk_subtractor                                          |
// | Description : Multi-cycle subtractor D = A - B - bin (mod 2^N), W bits per  |
// |               clock, least significant chunk first, with a registered       |
// |               borrow chaining the chunks. start/busy/done handshake plus    |
// |               borrow, signed-overflow and zero status flags.                |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module seq_chunk_subtractor #(
  parameter int N = 64,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         zero
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  diff_q;
  logic [N-1:0]  diff_d;
  logic          borrow_q;
  logic [IW-1:0] idx_q;
  logic          busy_q;
  logic          done_q;
  logic          bout_q;
  logic          ovf_q;
  logic          zero_q;

  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic [W:0]    sub_w;

  // Select the operand chunks addressed by the current chunk index
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        a_chunk = a_q[k*W +: W];
        b_chunk = b_q[k*W +: W];
      end
    end
  end

  // One W-bit subtract slice; bit W of the zero-extended result is the borrow out
  assign sub_w = {1'b0, a_chunk} - {1'b0, b_chunk} - {{W{1'b0}}, borrow_q};

  // Merge the fresh chunk into the accumulated difference
  always_comb begin
    diff_d = diff_q;
    for (int k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        diff_d[k*W +: W] = sub_w[W-1:0];
      end
    end
  end

  // Control FSM with registered datapath and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            idx_q    <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          diff_q   <= diff_d;
          borrow_q <= sub_w[W];
          idx_q    <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            // Final chunk: flags are derived from the completed difference
            bout_q  <= sub_w[W];
            ovf_q   <= (a_q[N-1] != b_q[N-1]) && (diff_d[N-1] != a_q[N-1]);
            zero_q  <= (diff_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
`default_nettype wire
